timer: RTL
==========

# timer

Programmable interval timer for the HuC6280, selected by the MMU's timer chip enable (`CET_n`, physical `1FEC00`–`1FEFFF`). It is the responder at the far end of the MMU's chip-select decode. It provides:
- a 7-bit reload register and a run/stop control;
- a prescaled down-counter and an interrupt request line to the interrupt controller;
- CPU readback of the live count.

## Interface
Parameters:
- `PRESCALE`, default 1024: clocks per counter tick. Overridden to 16 when `TIMER_SIM_PRESCALE_EN` is defined.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `RDY`  in  1  CPU ready. Register writes occur only while high. Counting ignores it.
- `CET_n`  in  1  timer chip enable from MMU, active-low.
- `A0`  in  1  `PADDR[0]`. 0 selects the reload/counter register, 1 selects the control register.
- `we`  in  1  CPU write strobe, valid with `CET_n`.
- `d_in`  in  8  CPU write data.
- `d_out`  out  8  CPU read data, combinational.
- `irq_ack`  in  1  one-cycle acknowledge from the interrupt controller.
- `TIQ`  out  1  timer interrupt request, active-high, level.

## Operation
State:
- `reload[6:0]`
- `enable`
- `counter[6:0]`
- `prescaler` (`$clog2(PRESCALE)` bits)
- `irq_pending` (drives `TIQ`)

Register writes take effect on the posedge where `!CET_n && we && RDY`:
- `A0=0`: `reload <= d_in[6:0]`.
  - `d_in[7]` is ignored.
  - The running count is not affected. The new value is used at the next underflow or restart.
- `A0=1`: `enable <= d_in[0]`. Other bits are ignored.
  - On a 0→1 transition: `counter <= reload` and `prescaler <= PRESCALE-1` (restart).
  - Writing 1 while already enabled: no restart, counting continues.
  - Writing 0: counting freezes. `counter`, `prescaler` and `irq_pending` are retained.

Counting, performed every cycle that `enable` is set and no restart occurs:
- When `prescaler != 0`: `prescaler--`.
- When `prescaler == 0`: `prescaler <= PRESCALE-1` and one tick is taken:
  - `counter != 0`: `counter--`.
  - `counter == 0`: `counter <= reload` and `irq_pending <= 1` (underflow).
- Period from restart to first underflow, and between underflows: `(reload+1)*PRESCALE` clocks.
- `reload = 0` gives a period of `PRESCALE`.

Read path:
- `d_out = {1'b0, counter}` when `!CET_n && !we`, for either `A0`.
- `d_out = 8'h00` otherwise.

Interrupt:
- `irq_ack` clears `irq_pending` on the next edge.
- An underflow and `irq_ack` in the same cycle: set wins, `TIQ` stays 1.

## Timing
- Reset values:
  - `reload = 0`, `enable = 0`, `counter = 0`, `prescaler = PRESCALE-1`, `irq_pending = 0`.
  - `TIQ = 0`, `d_out = 8'h00`.
  - Reset mid-count aborts counting and drops `TIQ` on the next edge.
- Write latency: the register updates at the edge sampling the write. It is visible on `d_out` the following cycle.
- Underflow timing: with the restart write sampled at edge N, `TIQ` is high after edge `N + (reload+1)*PRESCALE`.
- Read latency: `d_out` is combinational from current state, valid in the same cycle `CET_n` is low.
- Boundary cases:
  - `RDY` low with a write strobe: the write is dropped; counting proceeds.
  - Restart write in the same cycle as a prescaler terminal count: the restart wins and no tick is taken.
  - Reload write in the same cycle as an underflow: the counter loads the old `reload`; the new value is stored for the next underflow.

## Configuration
- `TIMER_SIM_PRESCALE_EN` defined: `PRESCALE` is forced to 16 for fast simulation. All other behaviour is identical.
- Undefined: `PRESCALE` takes its parameter value, default 1024, matching hardware.

## Test plan
- Reset, then read `A0=0` with `CET_n=0`, `we=0` → `d_out=8'h00`, `TIQ=0`.
- Write reload `8'h82`, then write control `8'h01` at edge N (`PRESCALE=1024`):
  - `counter` reads 2 at N+1, 1 at N+1024, 0 at N+2048.
  - `TIQ` rises after edge N+3072 and `counter` reads 2.
- With `TIQ` high, pulse `irq_ack` → `TIQ=0` next cycle. Pulse `irq_ack` exactly on an underflow edge → `TIQ` remains 1.
- Running with `reload=5`, write control `8'h00` at counter=3 → counter holds 3 for 5000 cycles. Write `8'h01` → restart, counter reads 5.
- Write reload `8'h10` while counting with `reload=3` → the current period completes on the old count. After underflow, counter reads `8'h10`. A write with `RDY=0` changes nothing.
- Assert `reset` mid-count with `TIQ` high → next cycle `TIQ=0`, counter reads 0, and no further counting until re-enabled.

Source files
------------

// File: rtl/timer_if.sv
// CPU-side bus and interrupt signals between the MMU/CPU and the interval timer.
interface timer_if;
  logic       RDY;
  logic       CET_n;
  logic       A0;
  logic       we;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       irq_ack;
  logic       TIQ;

  modport master (
    output RDY, CET_n, A0, we, d_in, irq_ack,
    input  d_out, TIQ
  );

  modport slave (
    input  RDY, CET_n, A0, we, d_in, irq_ack,
    output d_out, TIQ
  );
endinterface

// File: rtl/timer.sv
// HuC6280 programmable interval timer: 7-bit reload, prescaled down-counter, level IRQ.
// Define TIMER_SIM_PRESCALE_EN to force a prescale of 16 for fast simulation.
module timer #(
  parameter int PRESCALE = 1024
) (
  input logic    clk,
  input logic    reset,
  timer_if.slave bus
);

`ifdef TIMER_SIM_PRESCALE_EN
  localparam int P = 16;
`else
  localparam int P = PRESCALE;
`endif
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(P - 1);

  logic [6:0]    reload;
  logic          enable;
  logic [6:0]    counter;
  logic [PW-1:0] prescaler;
  logic          irq_pending;

  logic wr;
  logic restart;
  logic tick;
  logic underflow;
  logic unused_d7;

  assign wr        = !bus.CET_n && bus.we && bus.RDY;
  // Only a 0->1 enable transition restarts; rewriting 1 lets the count run on.
  assign restart   = wr && bus.A0 && bus.d_in[0] && !enable;
  assign tick      = enable && !restart && (prescaler == '0);
  assign underflow = tick && (counter == '0);
  assign unused_d7 = bus.d_in[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      reload      <= '0;
      enable      <= 1'b0;
      counter     <= '0;
      prescaler   <= PRE_TOP;
      irq_pending <= 1'b0;
    end else begin
      if (wr && !bus.A0) reload <= bus.d_in[6:0];
      if (wr && bus.A0)  enable <= bus.d_in[0];

      if (restart) begin
        counter   <= reload;
        prescaler <= PRE_TOP;
      end else if (enable) begin
        if (prescaler != '0) begin
          prescaler <= prescaler - 1'b1;
        end else begin
          prescaler <= PRE_TOP;
          // Underflow reloads from the pre-write reload value.
          counter   <= (counter != '0) ? counter - 1'b1 : reload;
        end
      end

      // Set has priority over acknowledge.
      if (underflow)        irq_pending <= 1'b1;
      else if (bus.irq_ack) irq_pending <= 1'b0;
    end
  end

  assign bus.d_out = (!bus.CET_n && !bus.we) ? {1'b0, counter} : 8'h00;
  assign bus.TIQ   = irq_pending;

endmodule
